// File: rtl/btn_conditioner.sv
// btn_conditioner: push-button front end for the LED sweep/PWM top level.
// Turns a raw, bouncing, asynchronous button pin into a clean level in the
// clk domain plus single-cycle press, release, click and long-press events.
//
// FSM states
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_UP     | button released and stable, waiting for a synchronised 1
//   ST_DEB_DN | candidate press, counting consecutive 1 samples
//   ST_DOWN   | button pressed and stable, hold timer running
//   ST_DEB_UP | candidate release, counting consecutive 0 samples;
//             | level still reads pressed and the hold timer keeps running

module btn_conditioner #(
    parameter int SYNC_STAGES       = 2,
    parameter int DEBOUNCE_CYCLES   = 250000,
    parameter int LONG_PRESS_CYCLES = 25000000,
    parameter bit ACTIVE_LOW        = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic click_pulse,
    output logic long_pulse,
    output logic long_held
);

    localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);

    localparam logic [DEB_W-1:0]  DEB_LIMIT  = DEB_W'(DEBOUNCE_CYCLES);
    localparam logic [DEB_W-1:0]  DEB_ONE    = DEB_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(LONG_PRESS_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE   = HOLD_W'(1);

    typedef enum logic [1:0] {
        ST_UP     = 2'd0,
        ST_DEB_DN = 2'd1,
        ST_DOWN   = 2'd2,
        ST_DEB_UP = 2'd3
    } state_t;

    state_t                  state;
    logic [SYNC_STAGES-1:0]  sync_q;
    logic                    btn_pol;
    logic                    btn_sync;
    logic [DEB_W-1:0]        deb_cnt;
    logic [HOLD_W-1:0]       hold_cnt;
    logic [HOLD_W-1:0]       hold_next;
    logic                    hold_reach;

    // Polarity is fixed before the synchroniser so that reset (all zeros)
    // always means "not pressed" regardless of board wiring.
    assign btn_pol  = btn_raw ^ ACTIVE_LOW;
    assign btn_sync = sync_q[SYNC_STAGES-1];

    // Metastability chain bringing the pin into the clk domain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn_pol};
        end
    end

    // Saturating hold-timer step and the "limit reached this cycle" strobe.
    always_comb begin
        hold_next  = hold_cnt;
        hold_reach = 1'b0;
        if (hold_cnt != HOLD_LIMIT) begin
            hold_next = hold_cnt + HOLD_ONE;
        end
        if (hold_cnt == HOLD_LAST) begin
            hold_reach = 1'b1;
        end
    end

    // Debounce/hold state machine; every output is a register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= ST_UP;
            deb_cnt       <= '0;
            hold_cnt      <= '0;
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            click_pulse   <= 1'b0;
            long_pulse    <= 1'b0;
            long_held     <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            click_pulse   <= 1'b0;
            long_pulse    <= 1'b0;

            case (state)
                ST_UP: begin
                    if (btn_sync) begin
                        state   <= ST_DEB_DN;
                        deb_cnt <= DEB_ONE;
                    end
                end

                ST_DEB_DN: begin
                    if (!btn_sync) begin
                        state   <= ST_UP;
                        deb_cnt <= '0;
                    end else if (deb_cnt == DEB_LIMIT) begin
                        state       <= ST_DOWN;
                        deb_cnt     <= '0;
                        hold_cnt    <= '0;
                        btn_level   <= 1'b1;
                        press_pulse <= 1'b1;
                    end else begin
                        deb_cnt <= deb_cnt + DEB_ONE;
                    end
                end

                ST_DOWN: begin
                    hold_cnt <= hold_next;
                    if (hold_reach) begin
                        long_pulse <= 1'b1;
                        long_held  <= 1'b1;
                    end
                    if (!btn_sync) begin
                        state   <= ST_DEB_UP;
                        deb_cnt <= DEB_ONE;
                    end
                end

                ST_DEB_UP: begin
                    if (!btn_sync && (deb_cnt == DEB_LIMIT)) begin
                        // An accepted release beats a long press landing on
                        // the same cycle, so that hold still counts as a click.
                        state         <= ST_UP;
                        deb_cnt       <= '0;
                        hold_cnt      <= '0;
                        btn_level     <= 1'b0;
                        release_pulse <= 1'b1;
                        click_pulse   <= ~long_held;
                        long_held     <= 1'b0;
                    end else begin
                        hold_cnt <= hold_next;
                        if (hold_reach) begin
                            long_pulse <= 1'b1;
                            long_held  <= 1'b1;
                        end
                        if (btn_sync) begin
                            state   <= ST_DOWN;
                            deb_cnt <= '0;
                        end else begin
                            deb_cnt <= deb_cnt + DEB_ONE;
                        end
                    end
                end

                default: begin
                    state   <= ST_UP;
                    deb_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with SYNC_STAGES=2, DEBOUNCE_CYCLES=4,
// LONG_PRESS_CYCLES=20. Inputs change and outputs are sampled on the falling
// clock edge; "cycle c" below is the rising edge that first sees pattern slot c.

module tb_btn_conditioner;

    localparam int MAXC = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic btn_raw = 1'b0;
    logic btn_raw_al = 1'b1;

    logic btn_level, press_pulse, release_pulse, click_pulse, long_pulse, long_held;
    logic btn_level_al, press_pulse_al, release_pulse_al, click_pulse_al, long_pulse_al, long_held_al;

    bit use_al = 1'b0;
    logic obs_level, obs_press, obs_rel, obs_click, obs_long, obs_held;

    int errors = 0;
    int checks = 0;

    logic pat [MAXC];
    logic rst_pat [MAXC];
    logic lvl_hist [MAXC];
    logic held_hist [MAXC];

    int n_press, first_press, last_press;
    int n_rel, first_rel;
    int n_click, first_click;
    int n_long, first_long;
    int n_both;

    always #5 clk = ~clk;

    btn_conditioner #(
        .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .LONG_PRESS_CYCLES(20), .ACTIVE_LOW(1'b0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw),
        .btn_level(btn_level), .press_pulse(press_pulse), .release_pulse(release_pulse),
        .click_pulse(click_pulse), .long_pulse(long_pulse), .long_held(long_held)
    );

    btn_conditioner #(
        .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .LONG_PRESS_CYCLES(20), .ACTIVE_LOW(1'b1)
    ) dut_al (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw_al),
        .btn_level(btn_level_al), .press_pulse(press_pulse_al), .release_pulse(release_pulse_al),
        .click_pulse(click_pulse_al), .long_pulse(long_pulse_al), .long_held(long_held_al)
    );

    assign obs_level = use_al ? btn_level_al     : btn_level;
    assign obs_press = use_al ? press_pulse_al   : press_pulse;
    assign obs_rel   = use_al ? release_pulse_al : release_pulse;
    assign obs_click = use_al ? click_pulse_al   : click_pulse;
    assign obs_long  = use_al ? long_pulse_al    : long_pulse;
    assign obs_held  = use_al ? long_held_al     : long_held;

    task automatic clear_pat();
        for (int i = 0; i < MAXC; i++) begin
            pat[i]     = 1'b0;
            rst_pat[i] = 1'b1;
        end
    endtask

    task automatic set_pat(input int lo, input int hi, input logic v);
        for (int i = lo; i <= hi; i++) pat[i] = v;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        btn_raw    = 1'b0;
        btn_raw_al = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Plays pat/rst_pat for n cycles and records what the observed DUT did.
    task automatic run_pat(input int n);
        n_press = 0; first_press = -1; last_press = -1;
        n_rel = 0;   first_rel = -1;
        n_click = 0; first_click = -1;
        n_long = 0;  first_long = -1;
        n_both = 0;
        for (int c = 0; c < n; c++) begin
            rst_n      = rst_pat[c];
            btn_raw    = pat[c];
            btn_raw_al = ~pat[c];
            @(negedge clk);
            lvl_hist[c]  = obs_level;
            held_hist[c] = obs_held;
            if (obs_press) begin
                if (first_press < 0) first_press = c;
                last_press = c;
                n_press++;
            end
            if (obs_rel) begin
                if (first_rel < 0) first_rel = c;
                n_rel++;
            end
            if (obs_click) begin
                if (first_click < 0) first_click = c;
                n_click++;
            end
            if (obs_long) begin
                if (first_long < 0) first_long = c;
                n_long++;
            end
            if (obs_press && obs_rel) n_both++;
        end
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [5:0] outs;
        int hi_cnt;
        do_reset();
        outs = {btn_level, press_pulse, release_pulse, click_pulse, long_pulse, long_held};
        checks++;
        if (outs !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 000000", outs);
        end
        checks++;
        if (btn_level_al !== 1'b0) begin
            errors++;
            $display("FAIL reset_level_al: got %b expected 0", btn_level_al);
        end
        // Button pressed but reset held: nothing may happen.
        clear_pat();
        set_pat(0, 11, 1'b1);
        for (int i = 0; i < 12; i++) rst_pat[i] = 1'b0;
        run_pat(12);
        hi_cnt = 0;
        for (int i = 0; i < 12; i++) if (lvl_hist[i] !== 1'b0) hi_cnt++;
        checks++;
        if (hi_cnt != 0 || n_press != 0) begin
            errors++;
            $display("FAIL reset_held_quiet: got level_high=%0d presses=%0d expected 0 0", hi_cnt, n_press);
        end
    endtask

    task automatic test_clean_press();
        do_reset();
        clear_pat();
        set_pat(0, 19, 1'b1);
        run_pat(20);
        checks++;
        if (first_press != 6 || n_press != 1) begin
            errors++;
            $display("FAIL press_timing: got first=%0d count=%0d expected 6 1", first_press, n_press);
        end
        checks++;
        if (lvl_hist[5] !== 1'b0 || lvl_hist[6] !== 1'b1 || lvl_hist[19] !== 1'b1) begin
            errors++;
            $display("FAIL press_level: got c5=%b c6=%b c19=%b expected 0 1 1", lvl_hist[5], lvl_hist[6], lvl_hist[19]);
        end
        checks++;
        if (n_rel != 0 || n_long != 0 || n_click != 0) begin
            errors++;
            $display("FAIL press_no_other: got rel=%0d long=%0d click=%0d expected 0 0 0", n_rel, n_long, n_click);
        end
    endtask

    task automatic test_bounce();
        int hi_cnt;
        do_reset();
        clear_pat();
        set_pat(0, 2, 1'b1);
        set_pat(4, 6, 1'b1);
        run_pat(30);
        hi_cnt = 0;
        for (int i = 0; i < 30; i++) if (lvl_hist[i] !== 1'b0) hi_cnt++;
        checks++;
        if (hi_cnt != 0) begin
            errors++;
            $display("FAIL bounce_level: got high_cycles=%0d expected 0", hi_cnt);
        end
        checks++;
        if (n_press + n_rel + n_click + n_long != 0) begin
            errors++;
            $display("FAIL bounce_pulses: got %0d expected 0", n_press + n_rel + n_click + n_long);
        end
    endtask

    task automatic test_short_click();
        do_reset();
        clear_pat();
        set_pat(0, 9, 1'b1);
        run_pat(30);
        checks++;
        if (first_press != 6 || n_press != 1) begin
            errors++;
            $display("FAIL click_press: got first=%0d count=%0d expected 6 1", first_press, n_press);
        end
        checks++;
        if (first_rel != 16 || n_rel != 1) begin
            errors++;
            $display("FAIL click_release: got first=%0d count=%0d expected 16 1", first_rel, n_rel);
        end
        checks++;
        if (first_click != 16 || n_click != 1) begin
            errors++;
            $display("FAIL click_pulse: got first=%0d count=%0d expected 16 1", first_click, n_click);
        end
        checks++;
        if (n_long != 0 || n_both != 0) begin
            errors++;
            $display("FAIL click_no_long: got long=%0d overlap=%0d expected 0 0", n_long, n_both);
        end
        checks++;
        if (lvl_hist[15] !== 1'b1 || lvl_hist[16] !== 1'b0) begin
            errors++;
            $display("FAIL click_level: got c15=%b c16=%b expected 1 0", lvl_hist[15], lvl_hist[16]);
        end
    endtask

    task automatic test_long_press();
        do_reset();
        clear_pat();
        set_pat(0, 39, 1'b1);
        run_pat(60);
        checks++;
        if (first_long != 26 || n_long != 1) begin
            errors++;
            $display("FAIL long_pulse: got first=%0d count=%0d expected 26 1", first_long, n_long);
        end
        checks++;
        if (held_hist[25] !== 1'b0 || held_hist[26] !== 1'b1 || held_hist[45] !== 1'b1 || held_hist[46] !== 1'b0) begin
            errors++;
            $display("FAIL long_held: got c25=%b c26=%b c45=%b c46=%b expected 0 1 1 0",
                     held_hist[25], held_hist[26], held_hist[45], held_hist[46]);
        end
        checks++;
        if (first_rel != 46 || n_rel != 1 || n_click != 0) begin
            errors++;
            $display("FAIL long_release: got rel=%0d count=%0d click=%0d expected 46 1 0", first_rel, n_rel, n_click);
        end
    endtask

    task automatic test_hold_glitch();
        int lo_cnt;
        do_reset();
        clear_pat();
        set_pat(0, 39, 1'b1);
        set_pat(21, 22, 1'b0);
        run_pat(40);
        lo_cnt = 0;
        for (int i = 6; i < 40; i++) if (lvl_hist[i] !== 1'b1) lo_cnt++;
        checks++;
        if (lo_cnt != 0 || n_rel != 0 || n_click != 0) begin
            errors++;
            $display("FAIL glitch_level: got low_cycles=%0d rel=%0d click=%0d expected 0 0 0", lo_cnt, n_rel, n_click);
        end
        checks++;
        if (first_long != 26 || n_long != 1 || held_hist[39] !== 1'b1) begin
            errors++;
            $display("FAIL glitch_long: got first=%0d count=%0d held=%b expected 26 1 1", first_long, n_long, held_hist[39]);
        end
    endtask

    task automatic test_release_vs_long();
        // Release accepted on the very cycle the hold reaches the limit.
        do_reset();
        clear_pat();
        set_pat(0, 19, 1'b1);
        run_pat(40);
        checks++;
        if (first_rel != 26 || n_long != 0 || n_click != 1 || held_hist[26] !== 1'b0) begin
            errors++;
            $display("FAIL tie_release_wins: got rel=%0d long=%0d click=%0d held=%b expected 26 0 1 0",
                     first_rel, n_long, n_click, held_hist[26]);
        end
        // One cycle later: long press lands first, release is not a click.
        do_reset();
        clear_pat();
        set_pat(0, 20, 1'b1);
        run_pat(40);
        checks++;
        if (first_long != 26 || first_rel != 27 || n_rel != 1 || n_click != 0) begin
            errors++;
            $display("FAIL late_release: got long=%0d rel=%0d count=%0d click=%0d expected 26 27 1 0",
                     first_long, first_rel, n_rel, n_click);
        end
    endtask

    task automatic test_reset_mid_hold();
        do_reset();
        clear_pat();
        set_pat(0, 39, 1'b1);
        rst_pat[16] = 1'b0;
        run_pat(40);
        checks++;
        if (lvl_hist[15] !== 1'b1 || lvl_hist[16] !== 1'b0 || lvl_hist[22] !== 1'b0 || lvl_hist[23] !== 1'b1) begin
            errors++;
            $display("FAIL midreset_level: got c15=%b c16=%b c22=%b c23=%b expected 1 0 0 1",
                     lvl_hist[15], lvl_hist[16], lvl_hist[22], lvl_hist[23]);
        end
        checks++;
        if (n_press != 2 || first_press != 6 || last_press != 23) begin
            errors++;
            $display("FAIL midreset_press: got count=%0d first=%0d last=%0d expected 2 6 23", n_press, first_press, last_press);
        end
        checks++;
        if (n_rel != 0 || n_click != 0 || n_long != 0) begin
            errors++;
            $display("FAIL midreset_quiet: got rel=%0d click=%0d long=%0d expected 0 0 0", n_rel, n_click, n_long);
        end
    endtask

    task automatic test_active_low();
        use_al = 1'b1;
        do_reset();
        clear_pat();
        set_pat(5, 29, 1'b1);
        run_pat(30);
        checks++;
        if (lvl_hist[4] !== 1'b0 || lvl_hist[10] !== 1'b0 || lvl_hist[11] !== 1'b1) begin
            errors++;
            $display("FAIL al_level: got c4=%b c10=%b c11=%b expected 0 0 1", lvl_hist[4], lvl_hist[10], lvl_hist[11]);
        end
        checks++;
        if (first_press != 11 || n_press != 1) begin
            errors++;
            $display("FAIL al_press: got first=%0d count=%0d expected 11 1", first_press, n_press);
        end
        use_al = 1'b0;
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_short_click();
        test_long_press();
        test_hold_glitch();
        test_release_vs_long();
        test_reset_mid_hold();
        test_active_low();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
